// File: rtl/ray_sphere_scan_if.sv
// Handshake and configuration bundle for ray_sphere_scan.
// master = ray/config producer and result consumer, slave = the scan core.
interface ray_sphere_scan_if #(
    parameter int unsigned COORD_W     = 16,
    parameter int unsigned NUM_SPHERES = 4,
    parameter int unsigned TAG_W       = 20,
    parameter int unsigned IDX_W       = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1
);
    // Sphere slot configuration
    logic                      cfg_we;
    logic [IDX_W-1:0]          cfg_idx;
    logic                      cfg_en;
    logic signed [COORD_W-1:0] cfg_ox;
    logic signed [COORD_W-1:0] cfg_oy;
    logic signed [COORD_W-1:0] cfg_oz;
    logic signed [COORD_W-1:0] cfg_r;

    // Ray input channel
    logic                      in_valid;
    logic                      in_ready;
    logic signed [COORD_W-1:0] in_dx;
    logic signed [COORD_W-1:0] in_dy;
    logic signed [COORD_W-1:0] in_dz;
    logic [TAG_W-1:0]          in_tag;

    // Result channel
    logic                      out_valid;
    logic                      out_ready;
    logic [NUM_SPHERES-1:0]    out_hit;
    logic                      out_any;
    logic [IDX_W-1:0]          out_first;
    logic [TAG_W-1:0]          out_tag;

    modport master (
        output cfg_we, cfg_idx, cfg_en, cfg_ox, cfg_oy, cfg_oz, cfg_r,
        output in_valid, in_dx, in_dy, in_dz, in_tag,
        input  in_ready,
        input  out_valid, out_hit, out_any, out_first, out_tag,
        output out_ready
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_en, cfg_ox, cfg_oy, cfg_oz, cfg_r,
        input  in_valid, in_dx, in_dy, in_dz, in_tag,
        output in_ready,
        output out_valid, out_hit, out_any, out_first, out_tag,
        input  out_ready
    );
endinterface

// File: rtl/ray_sphere_scan.sv
// Multi-sphere ray discriminant scan: one ray in flight, one sphere slot tested per cycle.
// Produces a hit mask (disc >= 0 on enabled slots), its OR, and the lowest hit index.
module ray_sphere_scan #(
    parameter int unsigned COORD_W     = 16,
    parameter int unsigned NUM_SPHERES = 4,
    parameter int unsigned TAG_W       = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    ray_sphere_scan_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1;
    localparam int unsigned CW    = 2 * COORD_W + 2;  // a, c
    localparam int unsigned BW    = 2 * COORD_W + 3;  // b
    localparam int unsigned DW    = 4 * COORD_W + 7;  // disc

    localparam logic [IDX_W:0]          NumSlots = (IDX_W + 1)'(NUM_SPHERES);
    localparam logic [IDX_W-1:0]        LastIdx  = IDX_W'(NUM_SPHERES - 1);
    localparam logic signed [DW-1:0]    DiscZero = '0;

    typedef enum logic [1:0] {StIdle, StAreg, StScan, StDone} state_e;

    // Sphere slot store
    logic signed [COORD_W-1:0] ox_q [NUM_SPHERES];
    logic signed [COORD_W-1:0] oy_q [NUM_SPHERES];
    logic signed [COORD_W-1:0] oz_q [NUM_SPHERES];
    logic signed [CW-1:0]      c_q  [NUM_SPHERES];
    logic [NUM_SPHERES-1:0]    en_q;

    logic signed [CW-1:0] wr_ox, wr_oy, wr_oz, wr_r, wr_c;
    logic                 wr_ok;

    // Ray / FSM state
    state_e                    state_q, state_d;
    logic signed [COORD_W-1:0] dx_q, dx_d, dy_q, dy_d, dz_q, dz_d;
    logic [TAG_W-1:0]          tag_q, tag_d;
    logic signed [CW-1:0]      a_q, a_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [NUM_SPHERES-1:0]    hit_q, hit_d;
    logic                      in_ready_q, in_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic [NUM_SPHERES-1:0]    out_hit_q, out_hit_d;
    logic                      out_any_q, out_any_d;
    logic [IDX_W-1:0]          out_first_q, out_first_d;
    logic [TAG_W-1:0]          out_tag_q, out_tag_d;

    // Datapath
    logic signed [CW-1:0]   ax, ay, az, a_calc;
    logic signed [BW-1:0]   bdx, bdy, bdz, box, boy, boz, b_calc;
    logic signed [DW-1:0]   be, ae, ce, disc;
    logic                   slot_hit;
    logic [NUM_SPHERES-1:0] hit_scan;
    logic [IDX_W-1:0]       first_enc;

    // c = |o|^2 - r^2 is formed at write time so the scan only evaluates b per slot
    always_comb begin
        wr_ox = bus.cfg_ox;
        wr_oy = bus.cfg_oy;
        wr_oz = bus.cfg_oz;
        wr_r  = bus.cfg_r;
        wr_c  = wr_ox * wr_ox + wr_oy * wr_oy + wr_oz * wr_oz - wr_r * wr_r;
        wr_ok = bus.cfg_we && ({1'b0, bus.cfg_idx} < NumSlots);
    end

    // Slot store; a same-cycle scan read sees the pre-write contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= '0;
            for (int i = 0; i < int'(NUM_SPHERES); i++) begin
                ox_q[i] <= '0;
                oy_q[i] <= '0;
                oz_q[i] <= '0;
                c_q[i]  <= '0;
            end
        end else if (wr_ok) begin
            ox_q[bus.cfg_idx] <= bus.cfg_ox;
            oy_q[bus.cfg_idx] <= bus.cfg_oy;
            oz_q[bus.cfg_idx] <= bus.cfg_oz;
            c_q[bus.cfg_idx]  <= wr_c;
            en_q[bus.cfg_idx] <= bus.cfg_en;
        end
    end

    // a from the latched ray; b and disc for the slot under idx_q; full-width signed math
    always_comb begin
        ax       = dx_q;
        ay       = dy_q;
        az       = dz_q;
        a_calc   = ax * ax + ay * ay + az * az;
        bdx      = dx_q;
        bdy      = dy_q;
        bdz      = dz_q;
        box      = ox_q[idx_q];
        boy      = oy_q[idx_q];
        boz      = oz_q[idx_q];
        b_calc   = (bdx * box + bdy * boy + bdz * boz) <<< 1;
        be       = b_calc;
        ae       = a_q;
        ce       = c_q[idx_q];
        disc     = be * be - ((ae * ce) <<< 2);
        slot_hit = en_q[idx_q] && (disc >= DiscZero);
        hit_scan = hit_q;
        hit_scan[idx_q] = slot_hit;
        first_enc = '0;
        for (int i = int'(NUM_SPHERES) - 1; i >= 0; i--) begin
            if (hit_scan[i]) first_enc = IDX_W'(i);
        end
    end

    // FSM next state and registered-output next values
    always_comb begin
        state_d     = state_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        dz_d        = dz_q;
        tag_d       = tag_q;
        a_d         = a_q;
        idx_d       = idx_q;
        hit_d       = hit_q;
        out_valid_d = out_valid_q;
        out_hit_d   = out_hit_q;
        out_any_d   = out_any_q;
        out_first_d = out_first_q;
        out_tag_d   = out_tag_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    dx_d    = bus.in_dx;
                    dy_d    = bus.in_dy;
                    dz_d    = bus.in_dz;
                    tag_d   = bus.in_tag;
                    state_d = StAreg;
                end
            end
            StAreg: begin
                a_d     = a_calc;
                hit_d   = '0;
                idx_d   = '0;
                state_d = StScan;
            end
            StScan: begin
                hit_d = hit_scan;
                if (idx_q == LastIdx) begin
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    out_hit_d   = hit_scan;
                    out_any_d   = |hit_scan;
                    out_first_d = first_enc;
                    out_tag_d   = tag_q;
                    state_d     = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        in_ready_d = (state_d == StIdle);
    end

    // FSM and output registers; async reset aborts any ray in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            dx_q        <= '0;
            dy_q        <= '0;
            dz_q        <= '0;
            tag_q       <= '0;
            a_q         <= '0;
            idx_q       <= '0;
            hit_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_hit_q   <= '0;
            out_any_q   <= 1'b0;
            out_first_q <= '0;
            out_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            dz_q        <= dz_d;
            tag_q       <= tag_d;
            a_q         <= a_d;
            idx_q       <= idx_d;
            hit_q       <= hit_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_hit_q   <= out_hit_d;
            out_any_q   <= out_any_d;
            out_first_q <= out_first_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_hit   = out_hit_q;
    assign bus.out_any   = out_any_q;
    assign bus.out_first = out_first_q;
    assign bus.out_tag   = out_tag_q;
endmodule

// File: tb/tb_ray_sphere_scan.sv
// Directed bench for ray_sphere_scan: vector table plus backpressure, throughput and
// mid-scan reset sequences. Expected values are hand-derived disc = b^2 - 4ac results.
module tb_ray_sphere_scan;
    localparam int unsigned COORD_W     = 16;
    localparam int unsigned NUM_SPHERES = 4;
    localparam int unsigned TAG_W       = 20;
    localparam int unsigned NV          = 11;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    ray_sphere_scan_if #(
        .COORD_W(COORD_W), .NUM_SPHERES(NUM_SPHERES), .TAG_W(TAG_W)
    ) bus ();

    ray_sphere_scan #(
        .COORD_W(COORD_W), .NUM_SPHERES(NUM_SPHERES), .TAG_W(TAG_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic               we;
        logic [1:0]         idx;
        logic               en;
        logic signed [15:0] ox, oy, oz, r;
        logic signed [15:0] dx, dy, dz;
        logic [19:0]        tag;
        logic [3:0]         hit;
        logic               any;
        logic [1:0]         first;
    } vec_t;

    vec_t tv [NV];

    function automatic vec_t mk(input bit we, input int idx, input bit en,
                                input int ox, input int oy, input int oz, input int r,
                                input int dx, input int dy, input int dz, input int tag,
                                input int hit, input bit any, input int first);
        vec_t v;
        v.we = we; v.idx = 2'(idx); v.en = en;
        v.ox = 16'(ox); v.oy = 16'(oy); v.oz = 16'(oz); v.r = 16'(r);
        v.dx = 16'(dx); v.dy = 16'(dy); v.dz = 16'(dz);
        v.tag = 20'(tag); v.hit = 4'(hit); v.any = any; v.first = 2'(first);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic en, input logic signed [15:0] ox,
                             input logic signed [15:0] oy, input logic signed [15:0] oz,
                             input logic signed [15:0] r);
        bus.cfg_we = 1'b1; bus.cfg_idx = idx; bus.cfg_en = en;
        bus.cfg_ox = ox; bus.cfg_oy = oy; bus.cfg_oz = oz; bus.cfg_r = r;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    // Waits (bounded) for in_ready, then presents the ray for exactly the accept edge
    task automatic send_ray(input logic signed [15:0] dx, input logic signed [15:0] dy,
                            input logic signed [15:0] dz, input logic [19:0] tag);
        for (int k = 0; k < 30 && !bus.in_ready; k++) tick();
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_dx = dx; bus.in_dy = dy; bus.in_dz = dz; bus.in_tag = tag;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        for (int k = 0; k < 30 && !bus.out_valid; k++) tick();
        ok = bus.out_valid;
        check("out_valid_wait", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic check_result(input string pfx, input logic [3:0] hit, input logic any,
                                input logic [1:0] first, input logic [19:0] tag);
        check({pfx, "_hit"},   32'(bus.out_hit),   32'(hit));
        check({pfx, "_any"},   32'(bus.out_any),   32'(any));
        check({pfx, "_first"}, 32'(bus.out_first), 32'(first));
        check({pfx, "_tag"},   32'(bus.out_tag),   32'(tag));
    endtask

    initial begin
        bit ok;
        bit seen;
        int acc [$];

        // Slot0..3 programming and rays; comments give disc per relevant slot
        tv[0]  = mk(1, 0, 1,      0, 0, 10,   3,      0,  1, 0, 'h00001, 'b0001, 1, 0); // hmm
        tv[0]  = mk(1, 0, 1,      0, 0, 10,   3,      0,  0, 1, 'h00001, 'b0001, 1, 0); // s0 36
        tv[1]  = mk(0, 0, 0,      0, 0,  0,   0,      1,  0, 0, 'h00002, 'b0000, 0, 0); // s0 -364
        tv[2]  = mk(1, 2, 1,      3, 0,  4,   3,      0,  0, 1, 'h00003, 'b0101, 1, 0); // s2 tangent
        tv[3]  = mk(1, 0, 0,      0, 0, 10,   3,      0,  0, 1, 'h00004, 'b0100, 1, 2); // s0 off
        tv[4]  = mk(1, 2, 1,      3, 0,  4,   2,      0,  0, 1, 'h00005, 'b0000, 0, 0); // s2 -20
        tv[5]  = mk(1, 1, 1,      0, 5,  0,   2,      0,  1, 0, 'h00006, 'b0010, 1, 1); // s1 16
        tv[6]  = mk(1, 3, 0,      0, 7,  0,   1,      0,  1, 0, 'hABCDE, 'b0010, 1, 1); // s3 off
        tv[7]  = mk(1, 3, 1,      0, 7,  0,   1,      0,  1, 0, 'h00008, 'b1010, 1, 1); // s3 4
        tv[8]  = mk(0, 0, 0,      0, 0,  0,   0,      0, -3, 0, 'h00009, 'b1010, 1, 1); // 144, 36
        tv[9]  = mk(1, 0, 1,  30000, 0,  0, 100,      1,  0, 0, 'h0000A, 'b0001, 1, 0); // s0 40000
        tv[10] = mk(0, 0, 0,      0, 0,  0,   0, -32768,  0, 0, 'h0000B, 'b0001, 1, 0); // s0 2^30*40000

        bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_en = 1'b0;
        bus.cfg_ox = '0; bus.cfg_oy = '0; bus.cfg_oz = '0; bus.cfg_r = '0;
        bus.in_valid = 1'b0; bus.in_dx = '0; bus.in_dy = '0; bus.in_dz = '0; bus.in_tag = '0;
        bus.out_ready = 1'b1;

        // Reset values
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_hit",   32'(bus.out_hit),   32'd0);
        check("rst_out_any",   32'(bus.out_any),   32'd0);
        check("rst_out_first", 32'(bus.out_first), 32'd0);
        check("rst_out_tag",   32'(bus.out_tag),   32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Vector table
        for (int i = 0; i < int'(NV); i++) begin
            if (tv[i].we) cfg_write(tv[i].idx, tv[i].en, tv[i].ox, tv[i].oy, tv[i].oz, tv[i].r);
            send_ray(tv[i].dx, tv[i].dy, tv[i].dz, tv[i].tag);
            wait_out(ok);
            if (ok) check_result($sformatf("v%0d", i), tv[i].hit, tv[i].any, tv[i].first,
                                 tv[i].tag);
        end

        // Backpressure: result held for 10 cycles, no new ray accepted
        tick();
        bus.out_ready = 1'b0;
        send_ray(16'sd0, -16'sd3, 16'sd0, 20'h12345);
        wait_out(ok);
        if (ok) check_result("stall", 4'b1010, 1'b1, 2'd1, 20'h12345);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_ready", 32'(bus.in_ready),  32'd0);
            check("stall_hit",   32'(bus.out_hit),   32'b1010);
            check("stall_tag",   32'(bus.out_tag),   32'h12345);
        end
        bus.out_ready = 1'b1;
        tick();
        check("release_valid", 32'(bus.out_valid), 32'd0);
        check("release_ready", 32'(bus.in_ready),  32'd1);

        // Back-to-back rays: accept edges spaced NUM_SPHERES+3 cycles apart
        bus.in_dx = 16'sd0; bus.in_dy = 16'sd1; bus.in_dz = 16'sd0; bus.in_tag = 20'h00777;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 40 && acc.size() < 3; k++) begin
            if (bus.in_ready) acc.push_back(cyc);
            tick();
        end
        bus.in_valid = 1'b0;
        check("thru_accepts", 32'(acc.size()), 32'd3);
        if (acc.size() == 3) begin
            check("thru_gap0", 32'(acc[1] - acc[0]), 32'(NUM_SPHERES + 3));
            check("thru_gap1", 32'(acc[2] - acc[1]), 32'(NUM_SPHERES + 3));
        end
        wait_out(ok);
        if (ok) check_result("thru", 4'b1010, 1'b1, 2'd1, 20'h00777);
        tick();

        // Reset mid-scan: outputs drop immediately, ray discarded, slots cleared
        send_ray(16'sd0, 16'sd1, 16'sd0, 20'h00999);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mrst_in_ready",  32'(bus.in_ready),  32'd1);
        check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mrst_out_hit",   32'(bus.out_hit),   32'd0);
        check("mrst_out_any",   32'(bus.out_any),   32'd0);
        check("mrst_out_first", 32'(bus.out_first), 32'd0);
        check("mrst_out_tag",   32'(bus.out_tag),   32'd0);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        check("mrst_no_stale", 32'(seen), 32'd0);
        send_ray(16'sd0, 16'sd1, 16'sd0, 20'h00AAA);
        wait_out(ok);
        if (ok) check_result("post_rst", 4'b0000, 1'b0, 2'd0, 20'h00AAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
